// File: rtl/anim_pkg.sv
// Shared constants for the sprite animation clock generator: channel indices and default divisors.
package anim_pkg;

  localparam int NUM_CH_DEF   = 4;
  localparam int DIV_W_DEF    = 6;
  localparam int PRESCALE_DEF = 416667;

  localparam int CH_COIN   = 0;
  localparam int CH_QBLOCK = 1;
  localparam int CH_WALK   = 2;
  localparam int CH_ENEMY  = 3;

  localparam int DIV_COIN   = 8;
  localparam int DIV_QBLOCK = 16;
  localparam int DIV_WALK   = 4;
  localparam int DIV_ENEMY  = 12;

  // Packs the default divisors into the layout expected on the div port.
  function automatic logic [NUM_CH_DEF*DIV_W_DEF-1:0] default_div();
    logic [NUM_CH_DEF*DIV_W_DEF-1:0] d;
    d = '0;
    d[CH_COIN*DIV_W_DEF   +: DIV_W_DEF] = DIV_W_DEF'(DIV_COIN);
    d[CH_QBLOCK*DIV_W_DEF +: DIV_W_DEF] = DIV_W_DEF'(DIV_QBLOCK);
    d[CH_WALK*DIV_W_DEF   +: DIV_W_DEF] = DIV_W_DEF'(DIV_WALK);
    d[CH_ENEMY*DIV_W_DEF  +: DIV_W_DEF] = DIV_W_DEF'(DIV_ENEMY);
    return d;
  endfunction

endpackage

// File: rtl/anim_channel.sv
// One animation channel: counts frame ticks and flips its square wave every div frames.
module anim_channel
  import anim_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             frame_tick,
  input  logic             pause,
  input  logic [DIV_W-1:0] div,
  output logic             toggle,
  output logic             pulse
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt    <= '0;
      toggle <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (div == '0) begin
        cnt <= '0;
      end else if (frame_tick && !pause) begin
        // >= rather than == so a divisor lowered mid-count still wraps on the next tick
        if (cnt >= div - DIV_W'(1)) begin
          cnt    <= '0;
          toggle <= ~toggle;
          pulse  <= 1'b1;
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/anim_clock_gen.sv
// Frame-tick source plus NUM_CH independent sprite animation channels.
// Define ANIM_VSYNC_SYNC_EN to tick on vsync rising edges; otherwise a free-running prescaler ticks.
module anim_clock_gen
  import anim_pkg::*;
#(
  parameter int NUM_CH   = NUM_CH_DEF,
  parameter int DIV_W    = DIV_W_DEF,
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    vsync,
  input  logic                    pause,
  input  logic [NUM_CH*DIV_W-1:0] div,
  output logic [NUM_CH-1:0]       anim_toggle,
  output logic [NUM_CH-1:0]       anim_pulse,
  output logic [15:0]             frame_cnt
);

  logic vsync_q;
  logic frame_tick;

  // Resets high so a vsync already asserted when reset lifts is not seen as an edge.
  always_ff @(posedge clk) begin
    if (!rstn) vsync_q <= 1'b1;
    else       vsync_q <= vsync;
  end

`ifdef ANIM_VSYNC_SYNC_EN
  assign frame_tick = vsync & ~vsync_q;
`else
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0] prescaler;
  logic            unused_vsync_q;

  assign unused_vsync_q = vsync_q;
  assign frame_tick     = (prescaler == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (!rstn)           prescaler <= '0;
    else if (frame_tick) prescaler <= '0;
    else                 prescaler <= prescaler + PS_W'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rstn)           frame_cnt <= '0;
    else if (frame_tick) frame_cnt <= frame_cnt + 16'd1;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    anim_channel #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk       (clk),
      .rstn      (rstn),
      .frame_tick(frame_tick),
      .pause     (pause),
      .div       (div[k*DIV_W +: DIV_W]),
      .toggle    (anim_toggle[k]),
      .pulse     (anim_pulse[k])
    );
  end

endmodule

// File: tb/tb_anim_clock_gen.sv
// Directed bench for anim_clock_gen; works with or without ANIM_VSYNC_SYNC_EN (prescaler set to 5).
module tb_anim_clock_gen;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 6;
  localparam int PS     = 5;

  logic                    clk;
  logic                    rstn;
  logic                    vsync;
  logic                    pause;
  logic [NUM_CH*DIV_W-1:0] div;
  logic [NUM_CH-1:0]       anim_toggle;
  logic [NUM_CH-1:0]       anim_pulse;
  logic [15:0]             frame_cnt;

  int vecs;
  int errs;
  int ph;
  int fc_exp;

  anim_clock_gen #(
    .NUM_CH  (NUM_CH),
    .DIV_W   (DIV_W),
    .PRESCALE(PS)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .vsync      (vsync),
    .pause      (pause),
    .div        (div),
    .anim_toggle(anim_toggle),
    .anim_pulse (anim_pulse),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NUM_CH*DIV_W-1:0] pack(int d3, int d2, int d1, int d0);
    return {DIV_W'(d3), DIV_W'(d2), DIV_W'(d1), DIV_W'(d0)};
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge; ph mirrors the prescaler phase the DUT should hold after the edge.
  task automatic cycle();
    @(posedge clk);
    if (!rstn) ph = 0;
    else       ph = (ph == PS - 1) ? 0 : ph + 1;
    #1;
  endtask

  // Advance to just after the next frame-tick edge.
  task automatic frame();
`ifdef ANIM_VSYNC_SYNC_EN
    vsync = 1'b0;
    cycle();
    vsync = 1'b1;
    cycle();
`else
    int was;
    do begin
      was = ph;
      cycle();
    end while (was != PS - 1);
`endif
    fc_exp++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] et;
    logic [3:0] ep;
    vecs = 0; errs = 0; ph = 0; fc_exp = 0;
    rstn = 1'b0; vsync = 1'b1; pause = 1'b0; div = '0;

    // reset with vsync held high, then no tick until a fresh edge / full prescale
    repeat (2) cycle();
    chk("rst_toggle", 32'(anim_toggle), 32'h0);
    chk("rst_pulse",  32'(anim_pulse),  32'h0);
    chk("rst_fcnt",   32'(frame_cnt),   32'h0);
    rstn = 1'b1;
    repeat (4) cycle();
    chk("post_rst_no_tick", 32'(frame_cnt), 32'h0);
    frame();
    chk("first_tick_fcnt", 32'(frame_cnt), 32'(fc_exp));
    chk("first_tick_pulse", 32'(anim_pulse), 32'h0);

    // ch0 div=1 toggles every frame, ch1 div=3 every third, ch2 div=0 disabled
    div = pack(0, 0, 3, 1);
    for (int i = 1; i <= 9; i++) begin
      frame();
      et = {2'b00, 1'((i / 3) % 2), 1'(i % 2)};
      ep = {2'b00, (i % 3 == 0), 1'b1};
      chk("run_toggle", 32'(anim_toggle), 32'(et));
      chk("run_pulse",  32'(anim_pulse),  32'(ep));
      chk("run_fcnt",   32'(frame_cnt),   32'(fc_exp));
      cycle();
      chk("run_pulse_low", 32'(anim_pulse), 32'h0);
    end

    // pause across 3 ticks with ch0 div=4, then toggle on the 4th unpaused tick
    div = pack(0, 0, 0, 4);
    pause = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      frame();
      chk("pause_toggle", 32'(anim_toggle), 32'h3);
      chk("pause_pulse",  32'(anim_pulse),  32'h0);
      chk("pause_fcnt",   32'(frame_cnt),   32'(fc_exp));
    end
    pause = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      frame();
      chk("unpause_toggle", 32'(anim_toggle), (i == 4) ? 32'h2 : 32'h3);
      chk("unpause_pulse",  32'(anim_pulse),  (i == 4) ? 32'h1 : 32'h0);
    end

    // ch3 div=10 counts to 7, then div drops to 3: wraps on the very next tick
    div = pack(10, 0, 0, 0);
    for (int i = 1; i <= 7; i++) begin
      frame();
      chk("ch3_count_toggle", 32'(anim_toggle), 32'h2);
      chk("ch3_count_pulse",  32'(anim_pulse),  32'h0);
    end
    div = pack(3, 0, 0, 0);
    frame();
    chk("div_shrink_toggle", 32'(anim_toggle), 32'hA);
    chk("div_shrink_pulse",  32'(anim_pulse),  32'h8);

    // ch0 and ch3 both div=3 from zero: simultaneous wrap
    div = pack(3, 0, 0, 3);
    for (int i = 1; i <= 3; i++) begin
      frame();
      chk("simul_toggle", 32'(anim_toggle), (i == 3) ? 32'h3 : 32'hA);
      chk("simul_pulse",  32'(anim_pulse),  (i == 3) ? 32'h9 : 32'h0);
    end
    chk("simul_fcnt", 32'(frame_cnt), 32'(fc_exp));

    // reset mid-operation overrides pause/div/vsync
    pause = 1'b1;
    vsync = 1'b1;
    rstn = 1'b0;
    cycle();
    fc_exp = 0;
    chk("midrst_toggle", 32'(anim_toggle), 32'h0);
    chk("midrst_pulse",  32'(anim_pulse),  32'h0);
    chk("midrst_fcnt",   32'(frame_cnt),   32'h0);
    rstn = 1'b1;
    repeat (4) cycle();
    chk("midrst_no_tick", 32'(frame_cnt), 32'h0);
    frame();
    chk("midrst_tick_fcnt",  32'(frame_cnt),   32'(fc_exp));
    chk("midrst_tick_pulse", 32'(anim_pulse),  32'h0);
    pause = 1'b0;
    frame();
    frame();
    frame();
    chk("midrst_resume_toggle", 32'(anim_toggle), 32'h9);
    chk("midrst_resume_fcnt",   32'(frame_cnt),   32'(fc_exp));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/anim_clock_gen.md
ANIM_CLOCK_GEN -- requirements
Module: anim_clock_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent animation channels.
REQ-002 SHALL have parameter DIV_W, default 6, width of each channel's frame divisor.
REQ-003 SHALL have parameter PRESCALE, default 416667, clk cycles per internal frame tick when vsync sync is compiled out.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port vsync  input  1  frame-sync level from the VGA timing block, already in clk domain.
REQ-007 SHALL have port pause  input  1  high freezes all channel counters and toggles.
REQ-008 SHALL have port div  input  NUM_CH*DIV_W  per-channel divisor, channel k at bits [k*DIV_W +: DIV_W], in frames per half-period.
REQ-009 SHALL have port anim_toggle  output  NUM_CH  per-channel square wave; consumers advance one sprite frame on each level change.
REQ-010 SHALL have port anim_pulse  output  NUM_CH  one-cycle strobe, coincident with each anim_toggle change.
REQ-011 SHALL have port frame_cnt  output  16  count of frame ticks since reset.

Function
REQ-012 SHALL register vsync into vsync_q each cycle; frame_tick = vsync & ~vsync_q (combinational, rising edge only).
REQ-013 SHALL increment frame_cnt on every frame_tick regardless of pause; wraps 0xFFFF -> 0x0000.
REQ-014 Per channel: on a clock edge with frame_tick=1, pause=0, div_k>=1: if cnt_k >= div_k-1 then cnt_k<=0, anim_toggle[k] inverts, anim_pulse[k]<=1; else cnt_k<=cnt_k+1.
REQ-015 anim_pulse[k] SHALL be 0 on every cycle not covered by REQ-014 wrap; never high two consecutive cycles.
REQ-016 Latency: vsync rises on cycle N -> anim_toggle/anim_pulse change visible on cycle N+1 (registered from frame_tick on cycle N edge).
REQ-017 div_k==0 SHALL disable channel k: cnt_k held at 0, anim_toggle[k] holds, anim_pulse[k]=0.
REQ-018 div changed mid-count SHALL take effect on the next frame_tick; the >= compare in REQ-014 guarantees wrap when cnt_k exceeds the new limit.
REQ-019 pause=1 coincident with frame_tick: pause wins for channels (no count, no toggle, no pulse); frame_cnt still increments.
REQ-020 vsync held high SHALL produce exactly one frame_tick; glitch-free edges assumed from the timing block.
REQ-021 Channels SHALL be fully independent; simultaneous wraps on several channels all pulse on the same cycle.

Reset
REQ-022 On rstn=0 at a clock edge: cnt_k=0, anim_toggle=0, anim_pulse=0, frame_cnt=0, vsync_q=1 (so vsync high out of reset does not create a tick), prescaler=0.
REQ-023 Reset mid-operation SHALL override pause, frame_tick and div; first possible tick is the first vsync rising edge after rstn returns high.

Configuration
REQ-024 Macro ANIM_VSYNC_SYNC_EN defined: frame_tick derived from vsync per REQ-012.
REQ-025 Macro ANIM_VSYNC_SYNC_EN undefined: vsync ignored; free-running prescaler counts 0..PRESCALE-1, frame_tick=1 on the cycle it equals PRESCALE-1, then wraps to 0; all other requirements unchanged.

Structure
REQ-026 Package anim_pkg SHALL hold NUM_CH, DIV_W defaults, channel index constants CH_COIN=0, CH_QBLOCK=1, CH_WALK=2, CH_ENEMY=3, and default divisors (coin 8, qblock 16, walk 4, enemy 12).
REQ-027 Sub-module anim_channel SHALL implement REQ-014/015/017/018 for one channel, instantiated NUM_CH times by generate.

Verification
REQ-028 Reset, div_0=1, vsync pulses every 10 cycles x4 -> anim_toggle[0] = 1,0,1,0 one cycle after each edge, anim_pulse[0] 4 single-cycle strobes, frame_cnt=4.
REQ-029 div_1=3, 9 vsync edges -> anim_toggle[1] inverts after edges 3, 6, 9 only; cnt_1 returns 0 each time.
REQ-030 div_2=0, 5 vsync edges -> anim_toggle[2] stays 0, anim_pulse[2] never high, frame_cnt=5.
REQ-031 div_0=4, pause=1 held across 3 vsync edges then released -> no toggles during pause, frame_cnt advances by 3, toggle on 4th unpaused edge.
REQ-032 div_3=10 with cnt_3=7, change div_3 to 3 -> wrap and toggle on very next frame_tick.
REQ-033 rstn low while vsync high, release -> no tick until vsync falls and rises again; with ANIM_VSYNC_SYNC_EN undefined and PRESCALE=5 -> frame_tick every 5 cycles.
